load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_align.sv | 44 ++++
 rtl/load_store_unit.sv | 200 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I funct3
// encodings, access-size decode and illegal-encoding detection.
package lsu_pkg;

  // Access sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  // Width of a single access, decoded from funct3[1:0].
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  // RV32I load encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // RV32I store encodings.
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Encodings with no RV32I load/store meaning; they fault without a bus access.
  localparam logic [2:0] F3_ILL_011 = 3'b011;
  localparam logic [2:0] F3_ILL_110 = 3'b110;
  localparam logic [2:0] F3_ILL_111 = 3'b111;

  // Width of the access selected by funct3 (signedness is handled downstream).
  function automatic lsu_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  // True for funct3 values that must fault immediately.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == F3_ILL_011) || (f3 == F3_ILL_110) || (f3 == F3_ILL_111);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store strobes, store-data
// lane replication and load-data right shift. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_shifted
);

  // Strobes and replicated store data from access size and byte offset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wstrb       = 4'b0000;
    wdata_lanes = wdata;
    case (f3_size(funct3))
      SZ_B: begin
        wdata_lanes = {4{wdata[7:0]}};
        wstrb       = 4'b0001 << offset;
      end
      SZ_H: begin
        wdata_lanes = {2{wdata[15:0]}};
        wstrb       = 4'b0011 << offset;
      end
      default: begin
        wdata_lanes = wdata;
        wstrb       = 4'b1111;
      end
    endcase
    // Loads never write any lane.
    if (!we) begin
      wstrb = 4'b0000;
    end
  end

  // Move the addressed byte down to bits [7:0] for the load-extension unit.
  assign rdata_shifted = rdata >> {offset, 3'b000};

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one access from the datapath, runs a
// request/response handshake on a word-wide bus, and returns a one-cycle
// completion pulse with shifted load data or a fault.
// Build option: define MISALIGN_TRAP_EN to fault misaligned halfword/word
// accesses instead of silently clearing the offending low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        fault,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_resp_err
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        bus_req_valid_q, bus_req_valid_d;
  logic        resp_valid_q, resp_valid_d;
  logic        fault_q, fault_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  lsu_size_e   req_size;
  logic        req_illegal;
  logic        req_misaligned;
  logic [31:0] req_addr_eff;
  logic [15:0] cnt_inc;
  logic        timeout_hit;
  logic [31:0] rdata_shifted;

  assign req_illegal = f3_illegal(req_funct3);
  assign cnt_inc     = cnt_q + 16'd1;
  // The current REQ/WAIT cycle is the last one allowed.
  assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

  // Alignment policy for the incoming request: trap, or clear the low bits.
  always_comb begin
    req_size       = f3_size(req_funct3);
    req_addr_eff   = req_addr;
`ifdef MISALIGN_TRAP_EN
    req_misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                     ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    req_misaligned = 1'b0;
    case (req_size)
      SZ_H:    req_addr_eff[0]   = 1'b0;
      SZ_W:    req_addr_eff[1:0] = 2'b00;
      default: req_addr_eff      = req_addr;
    endcase
`endif
  end

  lsu_align u_align (
    .we            (we_q),
    .funct3        (funct3_q),
    .offset        (addr_q[1:0]),
    .wdata         (wdata_q),
    .rdata         (bus_rdata),
    .wstrb         (bus_wstrb),
    .wdata_lanes   (bus_wdata),
    .rdata_shifted (rdata_shifted)
  );

  // Next-state and registered-output logic for the access sequencer.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    funct3_d        = funct3_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    bus_req_valid_d = bus_req_valid_q;
    resp_valid_d    = 1'b0;
    fault_d         = 1'b0;
    resp_rdata_d    = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr_eff;
          wdata_d  = req_wdata;
          cnt_d    = 16'd0;
          if (req_illegal || req_misaligned) begin
            // Fault straight away; the bus never sees this access.
            state_d      = DONE;
            resp_valid_d = 1'b1;
            fault_d      = 1'b1;
            resp_rdata_d = 32'd0;
          end else begin
            state_d         = REQ;
            bus_req_valid_d = 1'b1;
          end
        end
      end

      REQ: begin
        cnt_d = cnt_inc;
        // The timeout wins over a late grant so REQ+WAIT never exceeds TIMEOUT cycles.
        if (timeout_hit) begin
          state_d         = DONE;
          bus_req_valid_d = 1'b0;
          resp_valid_d    = 1'b1;
          fault_d         = 1'b1;
          resp_rdata_d    = 32'd0;
        end else if (bus_req_ready) begin
          state_d         = WAIT;
          bus_req_valid_d = 1'b0;
        end
      end

      WAIT: begin
        cnt_d = cnt_inc;
        // A response arriving in the final allowed cycle still completes normally.
        if (bus_resp_valid) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          fault_d      = bus_resp_err;
          resp_rdata_d = (!we_q && !bus_resp_err) ? rdata_shifted : 32'd0;
        end else if (timeout_hit) begin
          state_d      = DONE;
          resp_valid_d = 1'b1;
          fault_d      = 1'b1;
          resp_rdata_d = 32'd0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d         = IDLE;
        bus_req_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any in-flight access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the latched request fields are reset too, so bus outputs are defined straight out of reset.
      state_q         <= IDLE;
      cnt_q           <= 16'd0;
      we_q            <= 1'b0;
      funct3_q        <= 3'b000;
      addr_q          <= 32'd0;
      wdata_q         <= 32'd0;
      bus_req_valid_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      fault_q         <= 1'b0;
      resp_rdata_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      we_q            <= we_d;
      funct3_q        <= funct3_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      bus_req_valid_q <= bus_req_valid_d;
      resp_valid_q    <= resp_valid_d;
      fault_q         <= fault_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign stall         = req_valid && (state_q != DONE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign fault         = fault_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_addr      = {addr_q[31:2], 2'b00};
  assign bus_we        = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// accesses against a behavioural model, with a bus responder and a
// scoreboard-driven response monitor.
module tb_load_store_unit;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, fault;
  logic [31:0] resp_rdata;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid, bus_resp_err;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          issue_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          bus_req_seen = 0;

  // Plan for the bus responder and expected bus fields of the current access.
  int          cur_r = 0, cur_w = 0;
  logic [31:0] cur_rdata = 32'd0;
  logic        cur_err = 1'b0, cur_nobus = 1'b0;
  logic [31:0] exp_addr = 32'd0, exp_wdata = 32'd0;
  logic [3:0]  exp_wstrb = 4'd0;
  logic        exp_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: result of one access from the ISA-level rules.
  function automatic void model(
    input  logic we, input logic [2:0] f3, input logic [31:0] addr,
    input  logic [31:0] wdata, input logic [31:0] rdata, input logic err,
    input  int r, input int w,
    output exp_t e, output logic nobus, output logic [31:0] baddr,
    output logic [31:0] bwdata, output logic [3:0] bstrb, output int breq_cycles);
    int unsigned size, off;
    logic [31:0] eaddr;
    logic illegal, misal, tmo;
    size    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
`ifdef MISALIGN_TRAP_EN
    misal = !illegal && ((addr % size) != 0);
    eaddr = addr;
`else
    misal = 1'b0;
    eaddr = addr - (addr % size);
`endif
    off    = eaddr % 4;
    nobus  = illegal || misal;
    baddr  = eaddr - off;
    bstrb  = we ? 4'(((1 << size) - 1) << off) : 4'd0;
    for (int i = 0; i < 4; i++) bwdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    tmo         = !nobus && (r + w + 2 > T);
    e.fault     = nobus || tmo || err;
    e.rdata     = (!we && !e.fault) ? (rdata >> (8 * off)) : 32'd0;
    e.lat       = nobus ? 1 : tmo ? int'(T) + 1 : r + w + 3;
    e.issue_cyc = 0;
    breq_cycles = nobus ? 0 : ((r + 1 < T) ? r + 1 : int'(T));
  endfunction

  // Bus responder: grants after cur_r REQ cycles, answers after cur_w WAIT cycles.
  initial begin
    int ph, rc, wc;
    ph = 0; rc = 0; wc = 0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0; bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_resp_err   = 1'b0;
      bus_rdata      = $urandom;
      if (reset || resp_valid) begin
        ph = 0; rc = 0; wc = 0;
      end else begin
        case (ph)
          0: begin
            if (bus_req_valid) begin
              bus_req_seen++;
              check("no_bus_req_expected", 32'(cur_nobus), 32'd0);
              check("bus_addr", bus_addr, exp_addr);
              check("bus_we", 32'(bus_we), 32'(exp_we));
              check("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
              if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
              if (rc == cur_r) begin
                bus_req_ready = 1'b1; ph = 1; wc = 0;
              end else begin
                rc++;
              end
            end else begin
              // Stray responses outside WAIT must be ignored.
              bus_resp_valid = ($urandom_range(0, 3) == 0);
              bus_resp_err   = $urandom_range(0, 1);
            end
          end
          1: begin
            if (wc == cur_w) begin
              bus_resp_valid = 1'b1;
              bus_rdata      = cur_rdata;
              bus_resp_err   = cur_err;
              ph = 2;
            end else begin
              wc++;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: stall rule every cycle, scoreboard compare on each completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      check("stall", 32'(stall), 32'(req_valid && !resp_valid));
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp_valid", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("fault", 32'(fault), 32'(e.fault));
          check("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
        end
      end
    end
  end

  // Issue one access at a negedge, hold it until completion, then drop it.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                         input int r, input int w);
    exp_t e;
    int   bc, b0;
    bit   got;
    model(we, f3, addr, wdata, rdata, err, r, w, e, cur_nobus, exp_addr, exp_wdata, exp_wstrb, bc);
    exp_we = we; cur_r = r; cur_w = w; cur_rdata = rdata; cur_err = err;
    e.issue_cyc = cyc;
    sb_q.push_back(e);
    b0 = bus_req_seen;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = resp_valid;
    end
    if (!got) begin
      check("resp_arrived", 32'd0, 32'd1);
      sb_q.delete();
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    check("bus_req_cycles", 32'(bus_req_seen - b0), 32'(bc));
  endtask

  // Assert reset while an access is in REQ or WAIT; nothing may complete.
  task automatic reset_mid(input bit in_wait);
    exp_t e;
    int   bc;
    model(1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'd0, 1'b0, 0, 0,
          e, cur_nobus, exp_addr, exp_wdata, exp_wstrb, bc);
    exp_we = 1'b0; cur_r = in_wait ? 0 : 20; cur_w = 20; cur_err = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_4000;
    @(negedge clk);
    if (in_wait) @(negedge clk);
    check(in_wait ? "pre_reset_bus_req_wait" : "pre_reset_bus_req_req",
          32'(bus_req_valid), in_wait ? 32'd0 : 32'd1);
    reset = 1'b1;
    #1;
    check("reset_bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_resp_rdata", resp_rdata, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    // A fresh access must start from IDLE with minimum latency.
    run_txn(1'b1, 3'b010, 32'h0000_5000, 32'h0BAD_F00D, 32'd0, 1'b0, 0, 0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    logic        we, err;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    int          r, w;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_bus_req_valid", 32'(bus_req_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // SW, immediate bus: full-word strobes, latency 3.
    run_txn(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 0);
    // LBU at offset 3: top byte lands in [7:0].
    run_txn(1'b0, 3'b100, 32'h0000_1003, 32'd0, 32'hAABB_CCDD, 1'b0, 0, 0);
    // SB at offset 2: byte replicated, lane 2 strobe.
    run_txn(1'b1, 3'b000, 32'h0000_2002, 32'h0000_0012, 32'd0, 1'b0, 1, 0);
    // SH at offset 2.
    run_txn(1'b1, 3'b001, 32'h0000_2006, 32'h1234_5678, 32'd0, 1'b0, 0, 1);
    // LW never granted: timeout fault after T cycles in REQ.
    run_txn(1'b0, 3'b010, 32'h0000_0040, 32'd0, 32'h1111_1111, 1'b0, 10, 0);
    // Grant arrives exactly on the last allowed cycle: still a timeout.
    run_txn(1'b0, 3'b010, 32'h0000_0044, 32'd0, 32'h2222_2222, 1'b0, 3, 0);
    // Response on the last allowed cycle: completes normally.
    run_txn(1'b0, 3'b010, 32'h0000_0048, 32'd0, 32'h3333_3333, 1'b0, 1, 1);
    // Response one cycle too late: timeout in WAIT.
    run_txn(1'b0, 3'b010, 32'h0000_004C, 32'd0, 32'h4444_4444, 1'b0, 2, 1);
    // Misaligned LH.
    run_txn(1'b0, 3'b001, 32'h0000_3001, 32'd0, 32'h1122_3344, 1'b0, 0, 0);
    // Illegal funct3 on load and store.
    run_txn(1'b0, 3'b011, 32'h0000_0100, 32'd0, 32'h5555_5555, 1'b0, 0, 0);
    run_txn(1'b1, 3'b111, 32'h0000_0104, 32'h6666_6666, 32'd0, 1'b0, 0, 0);
    // Bus error on a load and on a store.
    run_txn(1'b0, 3'b010, 32'h0000_0200, 32'd0, 32'h7777_7777, 1'b1, 0, 0);
    run_txn(1'b1, 3'b001, 32'h0000_0202, 32'hABCD_0123, 32'd0, 1'b1, 1, 0);
    // LHU at offset 2 back-to-back with LB at offset 1.
    run_txn(1'b0, 3'b101, 32'h0000_0302, 32'd0, 32'h8899_AABB, 1'b0, 0, 0);
    run_txn(1'b0, 3'b000, 32'h0000_0305, 32'd0, 32'hCAFE_F00D, 1'b0, 0, 0);

    // Reset during REQ and during WAIT.
    reset_mid(1'b0);
    reset_mid(1'b1);

    // Randomized accesses with random bus timing and idle gaps.
    for (int n = 0; n < 300; n++) begin
      we = $urandom_range(0, 1);
      if (we) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b011;
          4: f3 = 3'b110;
          default: f3 = 3'b111;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      addr  = $urandom;
      wdata = $urandom;
      rdata = $urandom;
      err   = ($urandom_range(0, 7) == 0);
      r     = $urandom_range(0, 4);
      w     = $urandom_range(0, 3);
      run_txn(we, f3, addr, wdata, rdata, err, r, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
